// File: rtl/upg_loader.sv
// Serial program loader: receives a framed byte stream, assembles little-endian
// 32-bit words and writes them to the instruction-memory programming port.
module upg_loader #(
  parameter int          ADDR_W      = 14,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          MAX_WORDS   = 16384,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_addr_o,
  output logic [31:0]       upg_data_o,
  output logic              upg_done_o,
  output logic              upg_err_o,
  output logic              busy_o
);

  // state | meaning
  // IDLE  | waiting for the sync byte after reset
  // CNT0  | expecting low byte of the word count
  // CNT1  | expecting high byte of the word count, range check
  // DATA  | assembling data words and issuing writes
  // CHK   | expecting the XOR checksum byte
  // DONE  | load complete, checksum good
  // ERR   | frame rejected (count, checksum or timeout)
  typedef enum logic [2:0] {IDLE, CNT0, CNT1, DATA, CHK, DONE, ERR} state_t;

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state;
  logic [7:0]        cnt_lo;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_q;
  logic [7:0]        chk;
  logic [TO_W-1:0]   to_cnt;
  logic [15:0]       cnt_n;
  logic              in_frame;
  logic              is_sync;

  assign cnt_n    = {rx_data_i, cnt_lo};
  assign in_frame = (state == CNT0) || (state == CNT1) || (state == DATA) || (state == CHK);
  assign is_sync  = rx_valid_i && (rx_data_i == SYNC_BYTE);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt_lo     <= '0;
      words_left <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      chk        <= '0;
      to_cnt     <= '0;
      upg_wen_o  <= 1'b0;
      upg_addr_o <= '0;
      upg_data_o <= '0;
      upg_done_o <= 1'b0;
      upg_err_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      upg_wen_o <= 1'b0;

      if (in_frame && !rx_valid_i) to_cnt <= to_cnt + TO_W'(1);
      else                         to_cnt <= '0;

      case (state)
        IDLE, DONE, ERR: begin
          if (is_sync) begin
            state      <= CNT0;
            upg_done_o <= 1'b0;
            upg_err_o  <= 1'b0;
            busy_o     <= 1'b1;
            word_idx   <= '0;
            byte_idx   <= '0;
            chk        <= '0;
          end
        end
        CNT0: begin
          if (rx_valid_i) begin
            cnt_lo <= rx_data_i;
            state  <= CNT1;
          end
        end
        CNT1: begin
          if (rx_valid_i) begin
            words_left <= cnt_n;
            if (cnt_n == 16'd0 || 32'(cnt_n) > MAX_WORDS) begin
              state     <= ERR;
              upg_err_o <= 1'b1;
              busy_o    <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (rx_valid_i) begin
            chk      <= chk ^ rx_data_i;
            asm_q    <= {rx_data_i, asm_q[23:8]};
            byte_idx <= byte_idx + 2'd1;
            // The fourth byte completes the word straight from the input, so
            // the write goes out the next cycle without holding off rx.
            if (byte_idx == 2'd3) begin
              upg_wen_o  <= 1'b1;
              upg_data_o <= {rx_data_i, asm_q};
              upg_addr_o <= word_idx;
              word_idx   <= word_idx + ADDR_W'(1);
              words_left <= words_left - 16'd1;
              if (words_left == 16'd1) state <= CHK;
            end
          end
        end
        CHK: begin
          if (rx_valid_i) begin
            busy_o <= 1'b0;
            if (rx_data_i == chk) begin
              state      <= DONE;
              upg_done_o <= 1'b1;
            end else begin
              state     <= ERR;
              upg_err_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (in_frame && !rx_valid_i && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        state     <= ERR;
        upg_err_o <= 1'b1;
        busy_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_upg_loader.sv
// Scoreboard bench for upg_loader: expected writes are queued with the stimulus
// and a negedge monitor pops and compares every write strobe.
module tb_upg_loader;
  localparam int ADDR_W = 14;
  localparam int TO     = 100;

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;

  logic              clk_i = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid_i = 1'b0;
  logic [7:0]        rx_data_i = 8'h00;
  logic              upg_wen_o;
  logic [ADDR_W-1:0] upg_addr_o;
  logic [31:0]       upg_data_o;
  logic              upg_done_o, upg_err_o, busy_o;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  logic prev_wen = 1'b0;

  upg_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .MAX_WORDS(16384), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .upg_wen_o(upg_wen_o), .upg_addr_o(upg_addr_o), .upg_data_o(upg_data_o),
    .upg_done_o(upg_done_o), .upg_err_o(upg_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (upg_wen_o) begin
      wr_t e;
      checks++;
      if (prev_wen) begin
        errors++;
        $display("FAIL wen_width: wen high on two consecutive cycles, required single-cycle pulse");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0h data=%08h, required no write", upg_addr_o, upg_data_o);
      end else begin
        e = exp_q.pop_front();
        if (upg_addr_o !== e.addr || upg_data_o !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   upg_addr_o, upg_data_o, e.addr, e.data);
        end
      end
    end
    prev_wen = upg_wen_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic status(input string name, input logic d, input logic e, input logic b);
    check({name, "_done"}, 32'(upg_done_o), 32'(d));
    check({name, "_err"},  32'(upg_err_o),  32'(e));
    check({name, "_busy"}, 32'(busy_o),     32'(b));
  endtask

  // Bytes start one step after a posedge; stream=1 keeps rx_valid_i high.
  task automatic send(input bq_t bq, input bit stream);
    foreach (bq[i]) begin
      rx_valid_i = 1'b1;
      rx_data_i  = bq[i];
      @(posedge clk_i); #1;
      rx_valid_i = 1'b0;
      if (!stream) begin
        @(posedge clk_i); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = ADDR_W'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  bq_t good  = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
  bq_t bad   = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2B};
  bq_t strm  = '{8'hA5, 8'h04, 8'h00,
                 8'hA5, 8'h01, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'hE1};

  initial begin
    int waited;
    rst_n = 1'b0;
    idle(3);
    check("reset_wen",  32'(upg_wen_o), 32'h0);
    check("reset_addr", 32'(upg_addr_o), 32'h0);
    check("reset_data", upg_data_o, 32'h0);
    status("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(1);

    // Noise before sync is ignored
    send('{8'h12, 8'h00}, 1'b0);
    status("pre_sync", 1'b0, 1'b0, 1'b0);

    push(0, 32'h12345678); push(1, 32'hDEADBEEF);
    send(good, 1'b0);
    idle(2);
    status("normal", 1'b1, 1'b0, 1'b0);

    // Non-sync byte in DONE is ignored
    send('{8'h3C}, 1'b0);
    status("done_ignore", 1'b1, 1'b0, 1'b0);

    push(0, 32'h12345678); push(1, 32'hDEADBEEF);
    send(bad, 1'b0);
    idle(2);
    status("bad_chk", 1'b0, 1'b1, 1'b0);

    push(0, 32'h12345678); push(1, 32'hDEADBEEF);
    send(good, 1'b0);
    idle(2);
    status("resend", 1'b1, 1'b0, 1'b0);

    send('{8'hA5, 8'h00, 8'h00}, 1'b0);
    idle(2);
    status("zero_cnt", 1'b0, 1'b1, 1'b0);

    send('{8'hA5, 8'h01, 8'h40}, 1'b0);
    idle(2);
    status("cnt_16385", 1'b0, 1'b1, 1'b0);

    // Exactly MAX_WORDS is accepted; abandon via reset
    send('{8'hA5, 8'h00, 8'h40}, 1'b0);
    status("cnt_16384", 1'b0, 1'b0, 1'b1);
    do_reset();

    // Timeout: no error shortly before the limit, error after it
    send('{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56}, 1'b1);
    idle(TO - 10);
    status("pre_timeout", 1'b0, 1'b0, 1'b1);
    waited = 0;
    while (!upg_err_o && waited < 3 * TO) begin
      idle(1);
      waited++;
    end
    status("timeout", 1'b0, 1'b1, 1'b0);

    // Reset after the 6th byte of a 2-word frame
    send('{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34}, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    check("midrst_addr", 32'(upg_addr_o), 32'h0);
    check("midrst_data", upg_data_o, 32'h0);
    status("midrst", 1'b0, 1'b0, 1'b0);
    push(0, 32'h12345678); push(1, 32'hDEADBEEF);
    send(good, 1'b0);
    idle(2);
    status("after_rst", 1'b1, 1'b0, 1'b0);

    // Streaming with 0xA5 inside the data
    push(0, 32'h030201A5); push(1, 32'h44332211);
    push(2, 32'hA5A5A5A5); push(3, 32'hA55AFF00);
    send(strm, 1'b1);
    idle(3);
    status("stream", 1'b1, 1'b0, 1'b0);
    check("hold_addr", 32'(upg_addr_o), 32'h3);
    check("hold_data", upg_data_o, 32'hA55AFF00);

    check("pending_writes", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
